// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl: arbitrates write/read requests onto one BRAM port, buffers read responses in order.
// Define BRAM_CTRL_RR_ARB_EN for round-robin arbitration on contention (default: fixed write priority).
module bram_port_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int RSP_DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             mem_write_en,
  output logic             mem_read_en,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] mem_data_out
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
`ifdef BRAM_CTRL_RR_ARB_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  typedef enum logic {GNT_WR, GNT_RD} grant_t;
  logic [WIDTH-1:0] fifo [RSP_DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic             inflight, rd_ok, rd_pref, wr_xfer, rd_xfer, push, pop;
  grant_t           last_grant;
  // Credit counts only registered state, so a same-cycle pop never frees a slot early.
  assign rd_ok    = (count + CW'(inflight)) < CW'(RSP_DEPTH);
  assign rd_pref  = !wr_valid || (RR_EN && last_grant == GNT_WR);
  assign rd_ready = !rst && rd_ok && rd_pref;
  assign wr_ready = !rst && !(rd_valid && rd_ok && rd_pref);
  assign wr_xfer  = wr_valid && wr_ready;
  assign rd_xfer  = rd_valid && rd_ready;
  assign push     = inflight;
  assign pop      = rsp_valid && rsp_ready;
  assign mem_write_en = wr_xfer;
  assign mem_read_en  = rd_xfer;
  assign mem_addr     = wr_xfer ? wr_addr : rd_xfer ? rd_addr : '0;
  assign mem_data_in  = wr_xfer ? wr_data : '0;
  assign rsp_valid    = count != '0;
  assign rsp_data     = rsp_valid ? fifo[rp] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      wp         <= '0;
      rp         <= '0;
      inflight   <= 1'b0;
      last_grant <= GNT_WR;
    end else begin
      inflight <= rd_xfer;
      if (wr_xfer) last_grant <= GNT_WR;
      else if (rd_xfer) last_grant <= GNT_RD;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= mem_data_out;
  end
endmodule

// File: tb/tb_bram_port_ctrl.sv
// tb_bram_port_ctrl: directed checks of arbitration, response ordering, back-pressure and reset.
module tb_bram_port_ctrl;
`ifdef BRAM_CTRL_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_valid = 1'b0, wr_ready, rd_valid = 1'b0, rd_ready;
  logic [9:0]  wr_addr = '0, rd_addr = '0, mem_addr;
  logic [15:0] wr_data = '0, rsp_data, mem_data_in, mem_data_out;
  logic        rsp_valid, rsp_ready = 1'b0, mem_write_en, mem_read_en;
  logic [15:0] ram [1024];
  int          n_run = 0, n_fail = 0;

  bram_port_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_data_in;
    if (mem_read_en) mem_data_out <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    mid();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_mem_we", 32'(mem_write_en), 0);
    chk("rst_mem_re", 32'(mem_read_en), 0);
    tick(); rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    mid();
    chk("idle_addr", 32'(mem_addr), 0);
    chk("idle_din", 32'(mem_data_in), 0);
    chk("idle_we", 32'(mem_write_en), 0);
    chk("idle_re", 32'(mem_read_en), 0);
    // write 0x1234 @5 then read it back: rsp_valid two cycles after mem_read_en
    tick(); wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 16'h1234;
    mid();
    chk("wr_we", 32'(mem_write_en), 1);
    chk("wr_addr", 32'(mem_addr), 5);
    chk("wr_din", 32'(mem_data_in), 32'h1234);
    tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd5;
    mid();
    chk("rd_re_t", 32'(mem_read_en), 1);
    chk("rd_addr_t", 32'(mem_addr), 5);
    tick(); rd_valid = 1'b0;
    mid();
    chk("rd_valid_t1", 32'(rsp_valid), 0);
    tick(); mid();
    chk("rd_valid_t2", 32'(rsp_valid), 1);
    chk("rd_data_t2", 32'(rsp_data), 32'h1234);
    tick(); mid();
    chk("rd_popped", 32'(rsp_valid), 0);
    // preload 0xA,0xB,0xC @1..3, then back-pressure
    for (int i = 1; i <= 3; i++) begin
      tick(); wr_valid = 1'b1; wr_addr = 10'(i); wr_data = 16'(9 + i);
    end
    tick(); wr_valid = 1'b0; rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd1;
    mid();
    chk("bp_rd1_ready", 32'(rd_ready), 1);
    tick(); rd_addr = 10'd2;
    mid();
    chk("bp_rd2_ready", 32'(rd_ready), 1);
    tick(); rd_addr = 10'd3;
    mid();
    chk("bp_rd3_ready", 32'(rd_ready), 0);
    chk("bp_rd3_re", 32'(mem_read_en), 0);
    chk("bp_head_a", 32'(rsp_data), 32'hA);
    tick(); mid();
    chk("bp_full_ready", 32'(rd_ready), 0);
    tick(); rsp_ready = 1'b1;
    mid();
    chk("bp_pop_no_credit", 32'(rd_ready), 0);
    chk("bp_out_a", 32'(rsp_data), 32'hA);
    tick(); mid();
    chk("bp_out_b", 32'(rsp_data), 32'hB);
    chk("bp_rd3_accept", 32'(mem_read_en), 1);
    chk("bp_rd3_addr", 32'(mem_addr), 3);
    tick(); rd_valid = 1'b0;
    mid();
    chk("bp_gap", 32'(rsp_valid), 0);
    tick(); mid();
    chk("bp_out_c_v", 32'(rsp_valid), 1);
    chk("bp_out_c", 32'(rsp_data), 32'hC);
    tick(); mid();
    chk("bp_drained", 32'(rsp_valid), 0);
    // full occupancy (count+inflight) with simultaneous push and pop
    tick(); rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd1;
    tick(); rd_addr = 10'd2;
    tick(); rd_addr = 10'd3; rsp_ready = 1'b1;
    mid();
    chk("full_pop_ready", 32'(rd_ready), 0);
    chk("full_head_a", 32'(rsp_data), 32'hA);
    tick(); mid();
    chk("full_head_b_v", 32'(rsp_valid), 1);
    chk("full_head_b", 32'(rsp_data), 32'hB);
    chk("full_rd3_ready", 32'(rd_ready), 1);
    tick(); rd_valid = 1'b0;
    mid();
    chk("full_gap", 32'(rsp_valid), 0);
    tick(); mid();
    chk("full_head_c", 32'(rsp_data), 32'hC);
    // collision: write priority, or W,R,W,R under round-robin (last grant was a read)
    for (int i = 0; i < 4; i++) begin
      tick(); wr_valid = 1'b1; wr_addr = 10'(10 + i); wr_data = 16'(256 + i);
      rd_valid = 1'b1; rd_addr = 10'd10;
      mid();
      chk($sformatf("col_wr_ready_%0d", i), 32'(wr_ready), RR ? 32'(i % 2 == 0) : 1);
      chk($sformatf("col_rd_re_%0d", i), 32'(mem_read_en), RR ? 32'(i % 2 == 1) : 0);
    end
    tick(); wr_valid = 1'b0; rd_valid = 1'b0;
    tick(); tick(); tick();
    mid();
    chk("col_flushed", 32'(rsp_valid), 0);
    tick(); rd_valid = 1'b1; rd_addr = 10'd10;
    mid();
    chk("col_rd_re", 32'(mem_read_en), 1);
    tick(); rd_valid = 1'b0;
    tick(); mid();
    chk("col_rd_data", 32'(rsp_data), 32'h100);
    // address wrap: top and bottom words are distinct
    tick(); wr_valid = 1'b1; wr_addr = 10'd1023; wr_data = 16'hBEEF;
    tick(); wr_addr = 10'd0; wr_data = 16'hCAFE;
    tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd1023;
    mid();
    chk("wrap_addr_top", 32'(mem_addr), 1023);
    tick(); rd_addr = 10'd0;
    mid();
    chk("wrap_re_bot", 32'(mem_read_en), 1);
    tick(); rd_valid = 1'b0;
    mid();
    chk("wrap_data_top", 32'(rsp_data), 32'hBEEF);
    tick(); mid();
    chk("wrap_data_bot", 32'(rsp_data), 32'hCAFE);
    // reset while a response is buffered and another read is in flight
    tick(); rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd5;
    tick(); rd_addr = 10'd1;
    tick(); rd_valid = 1'b0;
    mid();
    chk("mr_pre_valid", 32'(rsp_valid), 1);
    #1 rst = 1'b1; rd_valid = 1'b1;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    chk("mr_rd_ready", 32'(rd_ready), 0);
    tick(); tick(); rst = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("mr_no_rsp_%0d", i), 32'(rsp_valid), 0);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
